// File: rtl/fetch_queue.sv
// fetch_queue: PC generator plus a DEPTH-entry instruction queue between the ROM and decode.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency path from the ROM to decode while the queue is empty.
module fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
    parameter logic [ILEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [ILEN-1:0]        imem_inst,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [ILEN-1:0]        out_inst,
    output logic                   out_misaligned,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {RUN, HALT} fetchState_t;

    fetchState_t      state;
    logic [XLEN-1:0]  pc;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0]  pcQ_p1   [DEPTH];
    logic [ILEN-1:0]  instQ_p1 [DEPTH];
    logic             misQ_p1  [DEPTH];

    logic [XLEN-1:0]  redirectTarget;
    logic             pcAligned;
    logic             queueValid;
    logic             isFull;
    logic             vld_p1;
    logic             bypassActive;
    logic             bypassPop;
    logic             queuePop;
    logic             fetchSlot;
    logic             enq;
    logic [ILEN-1:0]  wrInst_p0;
    logic             wrMis_p0;

    assign imem_addr      = pc;
    assign occupancy      = count;
    assign redirectTarget = redirect_pc & ~XLEN'(1);

    assign pcAligned  = (pc[1:0] == 2'b00);
    assign queueValid = (count != '0);
    assign isFull     = (count == FULL_CNT);
    // Decode must never accept a head in a redirect cycle, since that head is being flushed.
    assign vld_p1     = queueValid & ~redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypassActive   = ~queueValid & (state == RUN) & ~redirect_valid & pcAligned;
    assign out_valid      = vld_p1 | bypassActive;
    assign out_pc         = bypassActive ? pc        : pcQ_p1[rdPtr];
    assign out_inst       = bypassActive ? imem_inst : instQ_p1[rdPtr];
    assign out_misaligned = bypassActive ? 1'b0      : misQ_p1[rdPtr];
`else
    assign bypassActive   = 1'b0;
    assign out_valid      = vld_p1;
    assign out_pc         = pcQ_p1[rdPtr];
    assign out_inst       = instQ_p1[rdPtr];
    assign out_misaligned = misQ_p1[rdPtr];
`endif

    assign bypassPop = bypassActive & out_ready;
    assign queuePop  = vld_p1 & out_ready;

    // Stage p0: fetch slot; a full queue may still accept when its head leaves this cycle.
    assign fetchSlot = (state == RUN) & ~redirect_valid & (~isFull | queuePop);
    assign enq       = fetchSlot & ~bypassPop;
    assign wrInst_p0 = pcAligned ? imem_inst : NOP_INST;
    assign wrMis_p0  = ~pcAligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            state <= RUN;
            pc    <= redirectTarget;
            rdPtr <= wrPtr;
            count <= '0;
        end else begin
            if (queuePop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (enq) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (enq && !queuePop) begin
                count <= count + CNT_W'(1);
            end else if (queuePop && !enq) begin
                count <= count - CNT_W'(1);
            end
            // A misaligned PC is queued once as a marker, then fetch parks until a redirect.
            if (fetchSlot) begin
                if (pcAligned) begin
                    pc <= pc + XLEN'(4);
                end else begin
                    state <= HALT;
                end
            end
        end
    end

    // Stage p1: queue storage, written only on enqueue.
    always_ff @(posedge clk) begin
        if (enq) begin
            pcQ_p1[wrPtr]   <= pc;
            instQ_p1[wrPtr] <= wrInst_p0;
            misQ_p1[wrPtr]  <= wrMis_p0;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, stall/drain, redirects, misaligned halt, async reset.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misaligned;
    logic [2:0]  occupancy;

    int nCompared   = 0;
    int nMismatched = 0;

    fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_misaligned (out_misaligned),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romWord(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    assign imem_inst = romWord(imem_addr);

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkHead(input string tag, input logic [63:0] expPc);
        checkEq({tag, "Valid"}, 64'(out_valid), 64'd1);
        checkEq({tag, "Pc"}, out_pc, expPc);
        checkEq({tag, "Inst"}, 64'(out_inst), 64'(romWord(expPc)));
        checkEq({tag, "Mis"}, 64'(out_misaligned), 64'd0);
    endtask

    // Issue a one-cycle redirect from a negedge and return at the following negedge.
    task automatic doRedirect(input string tag, input logic [63:0] target, input logic [63:0] expAddr);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        #1;
        checkEq({tag, "CycleValid"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        checkEq({tag, "GapValid"}, 64'(out_valid), 64'd0);
        checkEq({tag, "GapOcc"}, 64'(occupancy), 64'd0);
        checkEq({tag, "Addr"}, imem_addr, expAddr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);
        checkEq("rstValid", 64'(out_valid), 64'd0);
        checkEq("rstOcc", 64'(occupancy), 64'd0);
        checkEq("rstAddr", imem_addr, 64'h8000_0000);
        rst = 1'b1;

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkHead("stream", 64'h8000_0000 + 64'(4 * k));
            checkEq("streamOcc", 64'(occupancy), 64'd1);
        end

        out_ready = 1'b0;
        @(negedge clk);
        checkEq("fillOcc2", 64'(occupancy), 64'd2);
        checkEq("fillHead", out_pc, 64'h8000_0014);
        @(negedge clk);
        checkEq("fillOcc3", 64'(occupancy), 64'd3);
        checkEq("fillAddr", imem_addr, 64'h8000_0020);

        out_ready = 1'b1;
        doRedirect("redir100", 64'h8000_0100, 64'h8000_0100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkHead("after100", 64'h8000_0100 + 64'(4 * k));
            checkEq("after100Occ", 64'(occupancy), 64'd1);
        end

        doRedirect("redir102", 64'h8000_0102, 64'h8000_0102);
        @(negedge clk);
        checkEq("markValid", 64'(out_valid), 64'd1);
        checkEq("markMis", 64'(out_misaligned), 64'd1);
        checkEq("markInst", 64'(out_inst), 64'h0000_0013);
        checkEq("markPc", out_pc, 64'h8000_0102);
        checkEq("markOcc", 64'(occupancy), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkEq("haltValid", 64'(out_valid), 64'd0);
            checkEq("haltOcc", 64'(occupancy), 64'd0);
            checkEq("haltAddr", imem_addr, 64'h8000_0102);
        end

        doRedirect("redir200", 64'h8000_0200, 64'h8000_0200);
        @(negedge clk);
        checkHead("after200", 64'h8000_0200);

        doRedirect("redir301", 64'h8000_0301, 64'h8000_0300);
        @(negedge clk);
        checkHead("after301", 64'h8000_0300);

        out_ready = 1'b0;
        @(negedge clk);
        checkEq("preRstOcc2", 64'(occupancy), 64'd2);
        @(negedge clk);
        checkEq("preRstOcc3", 64'(occupancy), 64'd3);
        out_ready = 1'b1;
        @(negedge clk);
        checkEq("drainOcc3", 64'(occupancy), 64'd3);
        checkHead("drain", 64'h8000_0304);

        @(posedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b0;
        #1;
        checkEq("asyncValid", 64'(out_valid), 64'd0);
        checkEq("asyncOcc", 64'(occupancy), 64'd0);
        checkEq("asyncAddr", imem_addr, 64'h8000_0000);
        @(negedge clk);
        rst = 1'b1;

        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            checkEq("stallOcc", 64'(occupancy), (j < 4) ? 64'(j) : 64'd4);
        end
        checkEq("stallAddr", imem_addr, 64'h8000_0010);
        checkHead("stallHead", 64'h8000_0000);

        out_ready = 1'b1;
        for (int m = 1; m <= 8; m++) begin
            @(negedge clk);
            checkHead("fullPop", 64'h8000_0000 + 64'(4 * m));
            checkEq("fullPopOcc", 64'(occupancy), 64'd4);
            checkEq("fullPopAddr", imem_addr, 64'h8000_0010 + 64'(4 * m));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
